// File: rtl/cal_keypad_pkg.sv
// ---------------------------------------------------------------------------
// cal_keypad_pkg
// Shared types and constants for the calculator keypad scanner.
//   kp_state_t       : scanner FSM states
//   KEY_MAX_DIGIT    : highest key code treated as a digit by the decoder
//   KEY_ERROR        : code the decoder reports for an unusable key
//   DEFAULT_DEBOUNCE : default debounce length in clock cycles
//   clog2_min1       : $clog2 that never returns zero (for register widths)
// ---------------------------------------------------------------------------
package cal_keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    localparam logic [3:0]  KEY_MAX_DIGIT    = 4'd9;
    localparam logic [31:0] KEY_ERROR        = 32'habb;
    localparam int          DEFAULT_DEBOUNCE = 10;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// ---------------------------------------------------------------------------
// key_fifo
// Small synchronous FIFO with a registered head-of-queue output.
//   clk       : clock, posedge
//   i_rst_n   : asynchronous active-low reset (empties the queue)
//   i_push    : write request for i_data
//   i_data    : data to enqueue
//   i_ready   : consumer accepts o_data when o_valid && i_ready
//   o_data    : registered head entry, held while not popped
//   o_valid   : queue not empty
//   o_drop    : push refused this cycle (full with no simultaneous pop)
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module key_fifo
    import cal_keypad_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_drop
);

    localparam int AW = clog2_min1(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;
    logic             r_valid;

    logic             w_pop;
    logic             w_full;
    logic             w_push_acc;
    logic [AW-1:0]    w_rd_next;
    logic [AW:0]      w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_pop        = r_valid && i_ready;
    assign w_full       = (r_count == (AW+1)'(DEPTH));
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign w_push_acc   = i_push && (!w_full || w_pop);
    assign w_rd_next    = r_rd_ptr + AW'(w_pop);
    assign w_count_next = r_count + (AW+1)'(w_push_acc) - (AW+1)'(w_pop);

    // The entry that becomes head may be the one being written right now
    // (empty queue, or a single entry being popped while a new one arrives).
    assign w_head_next  = (w_push_acc && (r_wr_ptr == w_rd_next)) ? i_data
                                                                  : r_mem[w_rd_next];

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            // Head keeps its last value once the queue drains.
            if (w_count_next != '0) begin
                r_head <= w_head_next;
            end
        end
    end

    assign o_data  = r_head;
    assign o_valid = r_valid;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_scan_ctrl
// Matrix keypad scanner: drives one column at a time, samples the rows,
// debounces press and release, and queues one key code per accepted press.
//   clk      : clock, posedge
//   rst      : asynchronous active-low reset
//   rows     : raw row lines, active-high, asynchronous to clk
//   cols     : one-hot column drive, active-high
//   key      : head-of-queue key code = row*COLS + col
//   valid    : queue not empty
//   ready    : consumer takes key when valid && ready
//   overflow : sticky, a press was dropped because the queue was full
//   clear    : synchronous clear of overflow
// ---------------------------------------------------------------------------
module keypad_scan_ctrl
    import cal_keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int FIFO_DEPTH      = 4,
    parameter int KEY_W           = $clog2(ROWS*COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROWS-1:0]  rows,
    output logic [COLS-1:0]  cols,
    output logic [KEY_W-1:0] key,
    output logic             valid,
    input  logic             ready,
    output logic             overflow,
    input  logic             clear
);

    localparam int RW = clog2_min1(ROWS);
    localparam int CW = clog2_min1(COLS);
    localparam int SW = clog2_min1(SCAN_CYCLES);
    localparam int DW = clog2_min1(DEBOUNCE_CYCLES);

    // Row synchronizer
    logic [ROWS-1:0] r_sync1;
    logic [ROWS-1:0] r_rs;

    // Scanner state
    kp_state_t       r_state,    w_state_next;
    logic [CW-1:0]   r_col,      w_col_next;
    logic [RW-1:0]   r_row,      w_row_next;
    logic [SW-1:0]   r_scan_cnt, w_scan_cnt_next;
    logic [DW-1:0]   r_db_cnt,   w_db_cnt_next;
    logic            r_overflow;

    logic            w_push;
    logic            w_drop;
    logic            w_rs_any;
    logic            w_rs_hit;
    logic [RW-1:0]   w_lowest_row;
    logic [KEY_W-1:0] w_key_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_rs    <= '0;
        end else begin
            r_sync1 <= rows;
            r_rs    <= r_sync1;
        end
    end

    assign w_rs_any = |r_rs;
    assign w_rs_hit = r_rs[r_row];

    // Priority to the lowest row when several rows of a column are active.
    always_comb begin
        w_lowest_row = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (r_rs[i]) begin
                w_lowest_row = RW'(i);
            end
        end
    end

    assign w_key_code = KEY_W'(int'(r_row) * COLS + int'(r_col));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SCAN;
            r_col      <= '0;
            r_row      <= '0;
            r_scan_cnt <= '0;
            r_db_cnt   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_col      <= w_col_next;
            r_row      <= w_row_next;
            r_scan_cnt <= w_scan_cnt_next;
            r_db_cnt   <= w_db_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_col_next      = r_col;
        w_row_next      = r_row;
        w_scan_cnt_next = r_scan_cnt;
        w_db_cnt_next   = r_db_cnt;
        w_push          = 1'b0;

        case (r_state)
            SCAN: begin
                // Rows are looked at only on the last dwell cycle so the
                // synchronizer has settled on the column being driven.
                if (r_scan_cnt == SW'(SCAN_CYCLES - 1)) begin
                    w_scan_cnt_next = '0;
                    if (w_rs_any) begin
                        w_row_next    = w_lowest_row;
                        w_db_cnt_next = '0;
                        w_state_next  = PRESS_DB;
                    end else if (r_col == CW'(COLS - 1)) begin
                        w_col_next = '0;
                    end else begin
                        w_col_next = r_col + CW'(1);
                    end
                end else begin
                    w_scan_cnt_next = r_scan_cnt + SW'(1);
                end
            end

            PRESS_DB: begin
                if (!w_rs_hit) begin
                    w_state_next    = SCAN;
                    w_col_next      = '0;
                    w_scan_cnt_next = '0;
                    w_db_cnt_next   = '0;
                end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    w_push        = 1'b1;
                    w_state_next  = HELD;
                    w_db_cnt_next = '0;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end

            HELD: begin
                if (!w_rs_hit) begin
                    w_state_next  = RELEASE_DB;
                    w_db_cnt_next = '0;
                end
            end

            RELEASE_DB: begin
                if (w_rs_hit) begin
                    // Release bounce: back to held, no new event.
                    w_state_next  = HELD;
                    w_db_cnt_next = '0;
                end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    w_state_next    = SCAN;
                    w_col_next      = '0;
                    w_scan_cnt_next = '0;
                    w_db_cnt_next   = '0;
                end else begin
                    w_db_cnt_next = r_db_cnt + DW'(1);
                end
            end

            default: begin
                w_state_next    = SCAN;
                w_col_next      = '0;
                w_scan_cnt_next = '0;
                w_db_cnt_next   = '0;
            end
        endcase
    end

    // Column drive follows the column register; it stays frozen outside SCAN.
    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_cols
            assign cols[gi] = (r_col == CW'(gi));
        end
    endgenerate

    key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (w_key_code),
        .i_ready (ready),
        .o_data  (key),
        .o_valid (valid),
        .o_drop  (w_drop)
    );

    // Set wins over clear when both happen in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Directed bench for keypad_scan_ctrl with a 4x4 keypad model. key_mat bit
// r*4+c is a pressed switch connecting column c to row r.
// ---------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

    localparam int D = 10;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        ready = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        valid;
    logic        overflow;
    logic [15:0] key_mat = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        rows = '0;
        for (int r = 0; r < 4; r++) begin
            rows[r] = |(key_mat[r*4 +: 4] & cols);
        end
    end

    keypad_scan_ctrl #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rows     (rows),
        .cols     (cols),
        .key      (key),
        .valid    (valid),
        .ready    (ready),
        .overflow (overflow),
        .clear    (clear)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Wait for the first cycle of a column's dwell.
    task automatic wait_col_start(input logic [3:0] target);
        logic [3:0] prev;
        bit ok;
        ok = 0;
        prev = cols;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (cols == target && prev != target) begin
                ok = 1;
                break;
            end
            prev = cols;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_col_start: cols=%b never began column %b", cols, target);
        end
    endtask

    task automatic press_release(input int code);
        key_mat[code] = 1'b1;
        idle(40);
        key_mat[code] = 1'b0;
        idle(30);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle(3);
        checks++;
        if (cols !== 4'b0001 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: cols=%b valid=%b, want 0001/0", cols, valid);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (cols !== 4'b0001) begin
            errors++;
            $display("FAIL reset_cols: cols=%b, want 0001", cols);
        end
        checks++;
        if (valid !== 1'b0 || key !== 4'd0) begin
            errors++;
            $display("FAIL reset_fifo: valid=%b key=%0d, want 0/0", valid, key);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow: overflow=%b, want 0", overflow);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_press();
        int run = 0, t1 = -1, tv = -1, nvalid = 0;
        logic [3:0] k1 = '0, cols_rel = '0, resume_cols = '0;
        bit resumed = 0;
        ready = 1'b1;
        wait_col_start(4'b0001);
        key_mat[5] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) begin
                cols_rel = cols;
                key_mat[5] = 1'b0;
            end
            tick();
            run = (cols == 4'b0010) ? run + 1 : 0;
            if (run == 5 && t1 < 0) t1 = i;
            if (valid) begin
                nvalid++;
                if (tv < 0) begin
                    tv = i;
                    k1 = key;
                end
            end
            if (i >= 40 && !resumed && cols != 4'b0010) begin
                resumed = 1;
                resume_cols = cols;
            end
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL single_count: %0d valid cycles, want 1", nvalid);
        end
        checks++;
        if (k1 !== 4'd5) begin
            errors++;
            $display("FAIL single_key: key=%0d, want 5", k1);
        end
        checks++;
        if (tv - t1 != D) begin
            errors++;
            $display("FAIL single_latency: valid %0d cycles after debounce start, want %0d", tv - t1, D);
        end
        checks++;
        if (cols_rel !== 4'b0010) begin
            errors++;
            $display("FAIL single_frozen: cols=%b while held, want 0010", cols_rel);
        end
        checks++;
        if (resume_cols !== 4'b0001) begin
            errors++;
            $display("FAIL single_resume: cols=%b after release, want 0001", resume_cols);
        end
        $display("test_single_press: key=%0d valid_cycles=%0d latency=%0d", k1, nvalid, tv - t1);
    endtask

    task automatic test_glitch();
        int run = 1, nvalid = 0;
        bit done = 0;
        logic [3:0] after_cols = '0;
        wait_col_start(4'b1000);
        key_mat[11] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (i == 5) key_mat[11] = 1'b0;
            if (valid) nvalid++;
            if (!done) begin
                if (cols == 4'b1000) run++;
                else begin
                    done = 1;
                    after_cols = cols;
                end
            end
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL glitch_valid: %0d valid cycles, want 0", nvalid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL glitch_overflow: overflow=%b, want 0", overflow);
        end
        checks++;
        if (run <= 4) begin
            errors++;
            $display("FAIL glitch_detect: column 3 held %0d cycles, want more than 4", run);
        end
        checks++;
        if (after_cols !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_resume: cols=%b after abort, want 0001", after_cols);
        end
        $display("test_glitch: frozen=%0d valid_cycles=%0d next_cols=%b", run, nvalid, after_cols);
    endtask

    task automatic test_two_keys();
        bit got = 0;
        int extra = 0, wait2 = -1;
        logic [3:0] k1 = '0, k2 = '0;
        wait_col_start(4'b0001);
        key_mat[2]  = 1'b1;
        key_mat[10] = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (valid) begin
                got = 1;
                k1 = key;
            end
        end
        checks++;
        if (!got || k1 !== 4'd2) begin
            errors++;
            $display("FAIL two_first: got=%0d key=%0d, want key 2", got, k1);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid) extra++;
        end
        key_mat[2] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid) begin
                wait2 = i;
                k2 = key;
                break;
            end
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL two_extra: %0d extra valid cycles, want 0", extra);
        end
        checks++;
        if (wait2 < 0 || k2 !== 4'd10) begin
            errors++;
            $display("FAIL two_second: key=%0d after %0d cycles, want key 10", k2, wait2);
        end
        checks++;
        if (wait2 <= 2 * D) begin
            errors++;
            $display("FAIL two_rescan: second event after %0d cycles, want more than %0d", wait2, 2 * D);
        end
        key_mat[10] = 1'b0;
        idle(40);
        $display("test_two_keys: first=%0d second=%0d delay=%0d", k1, k2, wait2);
    endtask

    task automatic test_release_bounce();
        int nvalid = 0;
        logic [3:0] k1 = '0, cols_bounce = '0;
        wait_col_start(4'b0001);
        key_mat[7] = 1'b1;
        for (int i = 0; i < 140; i++) begin
            tick();
            if (valid) begin
                nvalid++;
                k1 = key;
            end
            if (i == 50) key_mat[7] = 1'b0;
            if (i == 53) key_mat[7] = 1'b1;
            if (i == 65) begin
                cols_bounce = cols;
                key_mat[7] = 1'b0;
            end
        end
        checks++;
        if (nvalid != 1 || k1 !== 4'd7) begin
            errors++;
            $display("FAIL bounce_events: %0d events last key=%0d, want 1 event key 7", nvalid, k1);
        end
        checks++;
        if (cols_bounce !== 4'b1000) begin
            errors++;
            $display("FAIL bounce_held: cols=%b after bounce, want 1000", cols_bounce);
        end
        $display("test_release_bounce: events=%0d key=%0d", nvalid, k1);
    endtask

    task automatic test_overflow();
        int codes [5] = '{1, 2, 3, 4, 9};
        ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            press_release(codes[n]);
            if (n == 0) begin
                checks++;
                if (valid !== 1'b1 || key !== 4'd1) begin
                    errors++;
                    $display("FAIL ovf_head: valid=%b key=%0d, want 1/1", valid, key);
                end
            end
            if (n == 3) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early: overflow=%b after 4 presses, want 0", overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || key !== 4'd1) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b key=%0d, want 1/1", overflow, key);
        end
        ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (valid !== 1'b1 || key !== 4'(codes[n])) begin
                errors++;
                $display("FAIL ovf_drain%0d: valid=%b key=%0d, want 1/%0d", n, valid, key, codes[n]);
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: valid=%b overflow=%b, want 0/1", valid, overflow);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b, want 0", overflow);
        end
        $display("test_overflow: drained 4 codes, overflow=%b", overflow);
    endtask

    task automatic test_reset_mid();
        int run = 0, nvalid = 0;
        bit hit = 0;
        ready = 1'b0;
        press_release(3);
        press_release(4);
        checks++;
        if (valid !== 1'b1 || key !== 4'd3) begin
            errors++;
            $display("FAIL rstmid_queued: valid=%b key=%0d, want 1/3", valid, key);
        end
        wait_col_start(4'b0001);
        key_mat[6] = 1'b1;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            run = (cols == 4'b0100) ? run + 1 : 0;
            if (run == 5) hit = 1;
        end
        idle(2);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || cols !== 4'b0001 || key !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_clear: valid=%b cols=%b key=%0d, want 0/0001/0", valid, cols, key);
        end
        key_mat[6] = 1'b0;
        idle(3);
        rst = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid) nvalid++;
        end
        checks++;
        if (nvalid != 0 || !hit) begin
            errors++;
            $display("FAIL rstmid_stale: %0d valid cycles after reset (debounce reached=%0d), want 0", nvalid, hit);
        end
        $display("test_reset_mid: stale_valid_cycles=%0d", nvalid);
    endtask

    initial begin
        test_reset();
        test_single_press();
        idle(20);
        test_glitch();
        idle(20);
        test_two_keys();
        test_release_bounce();
        idle(20);
        test_overflow();
        idle(20);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Synthesizable, parametrised matrix-keypad scanner for the calculator datapath. It drives one column at a time and samples the row lines. Each key press is debounced on both press and release, and each accepted press becomes one key code in a small output FIFO. The FIFO uses a valid/ready handshake and feeds the operand/operator decoder, where codes 0–9 are digits and 10–15 are operators. This block replaces the testbench-side key/valid stimulus path with real hardware behaviour.

## Interface
Parameters:
- ROWS, 4, number of keypad row inputs
- COLS, 4, number of keypad column outputs
- SCAN_CYCLES, 4, clock cycles each column is driven (≥2)
- DEBOUNCE_CYCLES, 10, consecutive stable cycles required for press or release
- FIFO_DEPTH, 4, key-code buffer entries (power of two)
- KEY_W, $clog2(ROWS*COLS), key code width (derived, do not override)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- rows  in  ROWS  raw row lines, active-high, asynchronous to clk
- cols  out  COLS  one-hot column drive, active-high
- key  out  KEY_W  head-of-FIFO key code = row*COLS + col
- valid  out  1  FIFO not empty; key is meaningful
- ready  in  1  consumer accepts key when valid && ready
- overflow  out  1  sticky: a press was dropped because the FIFO was full
- clear  in  1  synchronous clear of overflow only

## Operation
- rows passes through a 2-flop synchronizer, producing rs. All decisions use rs.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN
  - cols is one-hot on column c.
  - c advances every SCAN_CYCLES and wraps COLS-1 → 0.
  - rs is sampled only on the last dwell cycle of each column.
  - If rs ≠ 0, latch c and r = lowest set row index, freeze cols, and go to PRESS_DB.
- PRESS_DB
  - The counter counts cycles with rs[r]=1.
  - If rs[r]=0 in any cycle, go to SCAN with c=0 and no event.
  - When the count reaches DEBOUNCE_CYCLES, push r*COLS+c and go to HELD.
- HELD
  - cols stays frozen.
  - Remain while rs[r]=1. Go to RELEASE_DB when rs[r]=0.
- RELEASE_DB
  - The counter counts cycles with rs[r]=0.
  - If rs[r]=1, return to HELD. This produces no new event.
  - When the count reaches DEBOUNCE_CYCLES, go to SCAN with c=0.
- While any key is latched, other keys are ignored. There is no rollover.
- FIFO push and pop rules:
  - Pop occurs on valid && ready.
  - A push when full with no simultaneous pop is dropped and sets overflow.
  - A push and pop in the same cycle while full are both accepted.
  - Output order is strict FIFO.
- overflow has these rules:
  - Set has priority over clear in the same cycle.
  - Cleared only by clear or reset.

## Timing
- Reset values:
  - cols = 1 (column 0), key = 0, valid = 0, overflow = 0.
  - FSM in SCAN, counters = 0, FIFO empty, synchronizer = 0.
- A reset assertion mid-operation discards all state and FIFO contents immediately.
- rows → rs latency: 2 cycles.
- Press timing:
  - Let T be the sampling cycle that detects the press.
  - PRESS_DB checks T+1 … T+DEBOUNCE_CYCLES.
  - The push occurs at T+DEBOUNCE_CYCLES.
  - valid/key are visible at T+DEBOUNCE_CYCLES+1 if the FIFO was empty.
- key and valid are registered. key holds its value while valid && !ready.
- After the release debounce completes, cols returns to column 0 on the next cycle.
- Worst-case idle detection delay: COLS*SCAN_CYCLES + 2 cycles.

## Structure
- Package cal_keypad_pkg contains:
  - the FSM state enum kp_state_t;
  - constants KEY_MAX_DIGIT = 4'd9, KEY_ERROR = 32'habb, DEFAULT_DEBOUNCE = 10.
- Sub-module key_fifo (parameters WIDTH, DEPTH) handles push/pop, full/empty and registered head output. The top level holds the synchronizer, FSM, scan counter and debounce counter.

## Test plan
- Single press at row 1, col 1, held for 40 cycles, ready=1 → exactly one valid pulse with key=5, then cols resumes scanning from column 0.
- Press glitch of 6 cycles (< DEBOUNCE_CYCLES) at row 2, col 3 → no valid and no overflow; scanning resumes at column 0.
- Keys at row 0 and row 2 of col 2 pressed together → single event with key=2. Releasing row 0 while row 2 stays high → no event until re-scan, then key=10.
- Release bounce on key 7: a 3-cycle low, then high again, then a full release → only one key=7 event.
- ready=0 and five distinct presses 1, 2, 3, 4, 9:
  - overflow=1 after the fifth press;
  - raising ready drains 1, 2, 3, 4 in order;
  - clear → overflow=0.
- rst asserted mid-PRESS_DB with 2 entries queued → valid=0, cols=1 immediately; after release of reset, no stale codes appear.
